// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - RV32I(+M) control decoder with ID/EX control register and mul/div sequencer
module ctrl_decode_pipe #(
  parameter int MULDIV_EN  = 1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       valid_d,
  input  logic       stall_e,
  input  logic       flush_e,
  output logic [2:0] ImmSrcD,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       BranchE,
  output logic       JumpE,
  output logic       ALUSrcE,
  output logic [2:0] ResultSrcE,
  output logic [3:0] ALUControlE,
  output logic [2:0] MdOpE,
  output logic       MdStartE,
  output logic       StallD,
  output logic       IllegalE
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  typedef struct packed {
    logic       illegal;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [2:0] result_src;
    logic [3:0] alu_ctrl;
    logic [2:0] md_op;
    logic       md_start;
  } ctl_t;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  ctl_t             e_d, e_q;
  logic [2:0]       imm_src_d;
  logic [3:0]       alu_f3_d;
  logic             md_d;
  logic [CNT_W-1:0] md_last_d;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // ALU op selected by funct3; SUB only on R, SRA on R or I
  always_comb begin
    alu_f3_d = ALU_AND;
    case (funct3)
      3'b000:  alu_f3_d = (op == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_f3_d = ALU_SLL;
      3'b010:  alu_f3_d = ALU_SLT;
      3'b011:  alu_f3_d = ALU_SLTU;
      3'b100:  alu_f3_d = ALU_XOR;
      3'b101:  alu_f3_d = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3_d = ALU_OR;
      default: alu_f3_d = ALU_AND;
    endcase
  end

  always_comb begin
    e_d       = '0;
    imm_src_d = 3'b000;
    md_d      = 1'b0;
    case (op)
      OP_R: begin
        if (MULDIV_EN != 0 && funct7 == 7'b0000001) begin
          md_d         = 1'b1;
          e_d.reg_write  = 1'b1;
          e_d.result_src = 3'b100;
          e_d.md_op      = funct3;
          e_d.md_start   = 1'b1;
        end else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          e_d.reg_write = 1'b1;
          e_d.alu_ctrl  = alu_f3_d;
        end else begin
          e_d.illegal = 1'b1;
        end
      end
      OP_I: begin
        e_d.reg_write = 1'b1;
        e_d.alu_src   = 1'b1;
        e_d.alu_ctrl  = alu_f3_d;
      end
      OP_LOAD: begin
        e_d.reg_write  = 1'b1;
        e_d.alu_src    = 1'b1;
        e_d.result_src = 3'b001;
      end
      OP_STORE: begin
        e_d.mem_write = 1'b1;
        e_d.alu_src   = 1'b1;
        imm_src_d     = 3'b001;
      end
      OP_BR: begin
        e_d.branch   = 1'b1;
        e_d.alu_ctrl = ALU_SUB;
        imm_src_d    = 3'b010;
      end
      OP_JAL: begin
        e_d.reg_write  = 1'b1;
        e_d.jump       = 1'b1;
        e_d.result_src = 3'b010;
        imm_src_d      = 3'b011;
      end
      OP_JALR: begin
        e_d.reg_write  = 1'b1;
        e_d.jump       = 1'b1;
        e_d.alu_src    = 1'b1;
        e_d.result_src = 3'b010;
      end
      OP_LUI: begin
        e_d.reg_write  = 1'b1;
        e_d.alu_src    = 1'b1;
        e_d.result_src = 3'b011;
        imm_src_d      = 3'b100;
      end
      OP_AUIPC: begin
        e_d.reg_write = 1'b1;
        e_d.alu_src   = 1'b1;
        imm_src_d     = 3'b100;
      end
      default: e_d.illegal = 1'b1;
    endcase
  end

  assign md_last_d = funct3[2] ? DIV_LAST : MUL_LAST;

  // A single-cycle M op (last == 0) never enters BUSY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q     <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (flush_e) begin
      e_q     <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (stall_e || state_q == S_BUSY) begin
      e_q.md_start <= 1'b0;
      if (state_q == S_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_q <= S_IDLE;
      end
    end else begin
      e_q <= valid_d ? e_d : '0;
      if (valid_d && md_d && md_last_d != '0) begin
        state_q <= S_BUSY;
        cnt_q   <= md_last_d;
      end
    end
  end

  assign ImmSrcD     = imm_src_d;
  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign BranchE     = e_q.branch;
  assign JumpE       = e_q.jump;
  assign ALUSrcE     = e_q.alu_src;
  assign ResultSrcE  = e_q.result_src;
  assign ALUControlE = e_q.alu_ctrl;
  assign MdOpE       = e_q.md_op;
  assign MdStartE    = e_q.md_start;
  assign StallD      = (state_q == S_BUSY);
  assign IllegalE    = e_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb/tb_ctrl_decode_pipe.sv - testbench for ctrl_decode_pipe
module tb_ctrl_decode_pipe;

  typedef struct packed {
    logic       illegal;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [2:0] result_src;
    logic [3:0] alu_ctrl;
    logic [2:0] md_op;
    logic       md_start;
    logic       stall_d;
  } ctl_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         chk_imm;
    logic [2:0] imm;
    ctl_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset, valid_d, stall_e, flush_e;
  logic [6:0] op, funct7;
  logic [2:0] funct3;

  logic [2:0] imm_a, imm_b, imm_c, rs_a, rs_b, rs_c, mo_a, mo_b, mo_c;
  logic [3:0] ac_a, ac_b, ac_c;
  logic rw_a, mw_a, br_a, jp_a, as_a, ms_a, sd_a, il_a;
  logic rw_b, mw_b, br_b, jp_b, as_b, ms_b, sd_b, il_b;
  logic rw_c, mw_c, br_c, jp_c, as_c, ms_c, sd_c, il_c;
  ctl_t ca, cb, cc;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.MULDIV_EN(1), .MUL_CYCLES(1), .DIV_CYCLES(32)) dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .ImmSrcD(imm_a), .RegWriteE(rw_a), .MemWriteE(mw_a),
    .BranchE(br_a), .JumpE(jp_a), .ALUSrcE(as_a), .ResultSrcE(rs_a), .ALUControlE(ac_a),
    .MdOpE(mo_a), .MdStartE(ms_a), .StallD(sd_a), .IllegalE(il_a));

  ctrl_decode_pipe #(.MULDIV_EN(0), .MUL_CYCLES(1), .DIV_CYCLES(32)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .ImmSrcD(imm_b), .RegWriteE(rw_b), .MemWriteE(mw_b),
    .BranchE(br_b), .JumpE(jp_b), .ALUSrcE(as_b), .ResultSrcE(rs_b), .ALUControlE(ac_b),
    .MdOpE(mo_b), .MdStartE(ms_b), .StallD(sd_b), .IllegalE(il_b));

  ctrl_decode_pipe #(.MULDIV_EN(1), .MUL_CYCLES(3), .DIV_CYCLES(5)) dut_c (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .ImmSrcD(imm_c), .RegWriteE(rw_c), .MemWriteE(mw_c),
    .BranchE(br_c), .JumpE(jp_c), .ALUSrcE(as_c), .ResultSrcE(rs_c), .ALUControlE(ac_c),
    .MdOpE(mo_c), .MdStartE(ms_c), .StallD(sd_c), .IllegalE(il_c));

  assign ca = {il_a, rw_a, mw_a, br_a, jp_a, as_a, rs_a, ac_a, mo_a, ms_a, sd_a};
  assign cb = {il_b, rw_b, mw_b, br_b, jp_b, as_b, rs_b, ac_b, mo_b, ms_b, sd_b};
  assign cc = {il_c, rw_c, mw_c, br_c, jp_c, as_c, rs_c, ac_c, mo_c, ms_c, sd_c};

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op = o; funct3 = f3; funct7 = f7; valid_d = 1'b1;
  endtask

  function automatic ctl_t mk(bit il, bit rw, bit mw, bit br, bit jp, bit as,
                              logic [2:0] rs, logic [3:0] ac, logic [2:0] mo, bit ms);
    mk = {il, rw, mw, br, jp, as, rs, ac, mo, ms, 1'b0};
  endfunction

  // Reference decode from the instruction-class rules
  function automatic ctl_t ref_dec(logic [6:0] o, logic [2:0] f3, logic [6:0] f7, bit md_en);
    logic [3:0] base [8];
    bit is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui, is_m, legal;
    ctl_t c;
    base = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    c = '0;
    is_r = (o == 7'h33); is_i = (o == 7'h13); is_ld = (o == 7'h03); is_st = (o == 7'h23);
    is_br = (o == 7'h63); is_jal = (o == 7'h6f); is_jalr = (o == 7'h67);
    is_lui = (o == 7'h37); is_aui = (o == 7'h17);
    is_m = is_r && md_en && (f7 == 7'h01);
    legal = (is_r && (f7 == 7'h00 || f7 == 7'h20 || is_m)) || is_i || is_ld || is_st ||
            is_br || is_jal || is_jalr || is_lui || is_aui;
    if (!legal) begin
      c.illegal = 1'b1;
      return c;
    end
    c.reg_write = !(is_st || is_br);
    c.mem_write = is_st;
    c.branch = is_br;
    c.jump = is_jal || is_jalr;
    c.alu_src = is_i || is_ld || is_st || is_jalr || is_lui || is_aui;
    c.result_src = is_m ? 3'd4 : is_ld ? 3'd1 : (is_jal || is_jalr) ? 3'd2 : is_lui ? 3'd3 : 3'd0;
    if (is_br) c.alu_ctrl = 4'd1;
    else if ((is_r && !is_m) || is_i) begin
      c.alu_ctrl = base[f3];
      if (f3 == 3'd0 && is_r && f7[5]) c.alu_ctrl = 4'd1;
      if (f3 == 3'd5 && f7[5]) c.alu_ctrl = 4'd9;
    end
    c.md_op = is_m ? f3 : 3'd0;
    c.md_start = is_m;
    return c;
  endfunction

  function automatic bit ref_imm(logic [6:0] o, output logic [2:0] imm);
    imm = 3'd0;
    case (o)
      7'h03, 7'h13, 7'h67: begin imm = 3'd0; return 1'b1; end
      7'h23: begin imm = 3'd1; return 1'b1; end
      7'h63: begin imm = 3'd2; return 1'b1; end
      7'h6f: begin imm = 3'd3; return 1'b1; end
      7'h37, 7'h17: begin imm = 3'd4; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  vec_t vecs [$];
  ctl_t add_w;
  ctl_t m_e;
  int   m_left;
  int   held, stalls, starts;
  logic [2:0] eimm;
  logic [6:0] ops [11];

  initial begin
    add_w = mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd0, 3'd0, 0);
    vecs.push_back('{7'h33, 3'd0, 7'h00, 0, 3'd0, add_w});
    vecs.push_back('{7'h33, 3'd0, 7'h20, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd1, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd1, 7'h00, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd7, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd2, 7'h00, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd5, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd3, 7'h00, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd6, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd4, 7'h00, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd4, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd5, 7'h00, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd8, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd5, 7'h20, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd9, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd6, 7'h00, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd3, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd7, 7'h00, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd0, 4'd2, 3'd0, 0)});
    vecs.push_back('{7'h13, 3'd0, 7'h20, 1, 3'd0, mk(0, 1, 0, 0, 0, 1, 3'd0, 4'd0, 3'd0, 0)});
    vecs.push_back('{7'h13, 3'd5, 7'h20, 1, 3'd0, mk(0, 1, 0, 0, 0, 1, 3'd0, 4'd9, 3'd0, 0)});
    vecs.push_back('{7'h03, 3'd2, 7'h00, 1, 3'd0, mk(0, 1, 0, 0, 0, 1, 3'd1, 4'd0, 3'd0, 0)});
    vecs.push_back('{7'h23, 3'd2, 7'h00, 1, 3'd1, mk(0, 0, 1, 0, 0, 1, 3'd0, 4'd0, 3'd0, 0)});
    vecs.push_back('{7'h63, 3'd0, 7'h00, 1, 3'd2, mk(0, 0, 0, 1, 0, 0, 3'd0, 4'd1, 3'd0, 0)});
    vecs.push_back('{7'h6f, 3'd0, 7'h00, 1, 3'd3, mk(0, 1, 0, 0, 1, 0, 3'd2, 4'd0, 3'd0, 0)});
    vecs.push_back('{7'h67, 3'd0, 7'h00, 1, 3'd0, mk(0, 1, 0, 0, 1, 1, 3'd2, 4'd0, 3'd0, 0)});
    vecs.push_back('{7'h37, 3'd0, 7'h00, 1, 3'd4, mk(0, 1, 0, 0, 0, 1, 3'd3, 4'd0, 3'd0, 0)});
    vecs.push_back('{7'h17, 3'd0, 7'h00, 1, 3'd4, mk(0, 1, 0, 0, 0, 1, 3'd0, 4'd0, 3'd0, 0)});
    vecs.push_back('{7'h7f, 3'd0, 7'h00, 0, 3'd0, mk(1, 0, 0, 0, 0, 0, 3'd0, 4'd0, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd0, 7'h10, 0, 3'd0, mk(1, 0, 0, 0, 0, 0, 3'd0, 4'd0, 3'd0, 0)});
    vecs.push_back('{7'h33, 3'd0, 7'h01, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd4, 4'd0, 3'd0, 1)});
    vecs.push_back('{7'h33, 3'd3, 7'h01, 0, 3'd0, mk(0, 1, 0, 0, 0, 0, 3'd4, 4'd0, 3'd3, 1)});

    reset = 1'b1; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    op = 7'h00; funct3 = 3'd0; funct7 = 7'h00;
    tick(); tick();
    chk("reset_a", ca, 0);
    chk("reset_b", cb, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7);
      #1;
      if (vecs[i].chk_imm) chk($sformatf("imm[%0d]", i), imm_a, vecs[i].imm);
      tick();
      chk($sformatf("vec[%0d]", i), ca, vecs[i].exp);
    end

    // Long divide holds E for 32 cycles and stalls D for 31
    drive(7'h33, 3'd4, 7'h01);
    tick();
    held = 0; stalls = 0; starts = 0;
    for (int i = 0; i < 32; i++) begin
      if (ca.result_src == 3'd4) held++;
      if (ca.stall_d) stalls++;
      if (ca.md_start) starts++;
      if (i == 0) drive(7'h33, 3'd0, 7'h00);
      tick();
    end
    chk("div_held", held, 32);
    chk("div_stalls", stalls, 31);
    chk("div_starts", starts, 1);
    chk("div_then_add", ca, add_w);

    // Flush aborts a divide on its fifth BUSY cycle
    drive(7'h33, 3'd5, 7'h01);
    tick();
    repeat (4) tick();
    chk("flush_busy", ca.stall_d, 1);
    flush_e = 1'b1;
    drive(7'h33, 3'd0, 7'h00);
    tick();
    chk("flush_bubble", ca, 0);
    flush_e = 1'b0;
    tick();
    chk("flush_then_add", ca, add_w);

    // Asynchronous reset in the middle of BUSY
    drive(7'h33, 3'd6, 7'h01);
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1 chk("async_reset", ca, 0);
    #1 reset = 1'b0;
    valid_d = 1'b0;
    tick();

    // MULDIV_EN=0: mul is illegal, then bubble
    drive(7'h33, 3'd0, 7'h01);
    tick();
    chk("noext_mul", cb, mk(1, 0, 0, 0, 0, 0, 3'd0, 4'd0, 3'd0, 0));
    valid_d = 1'b0;
    tick();
    chk("bubble_a", ca, 0);
    chk("bubble_b", cb, 0);

    // Random stimulus on the MUL=3 / DIV=5 instance against the model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_e = '0; m_left = 0;
    chk("rand_reset", cc, 0);
    ops = '{7'h33, 7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
    for (int n = 0; n < 600; n++) begin
      op = ($urandom_range(0, 11) == 11) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      funct3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: funct7 = 7'h00;
        1: funct7 = 7'h20;
        2: funct7 = 7'h01;
        default: funct7 = 7'($urandom);
      endcase
      valid_d = ($urandom_range(0, 9) < 8);
      stall_e = ($urandom_range(0, 9) < 2);
      flush_e = ($urandom_range(0, 29) == 0);
      #1;
      if (ref_imm(op, eimm)) chk("rand_imm", imm_c, eimm);
      tick();
      if (flush_e) begin
        m_e = '0; m_left = 0;
      end else if (m_left > 0 || stall_e) begin
        m_e.md_start = 1'b0;
        if (m_left > 0) m_left--;
      end else begin
        m_e = valid_d ? ref_dec(op, funct3, funct7, 1'b1) : '0;
        if (valid_d && m_e.md_start) m_left = (funct3[2] ? 5 : 3) - 1;
      end
      m_e.stall_d = (m_left > 0);
      chk($sformatf("rand[%0d]", n), cc, m_e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
